// File: rtl/fsm_tx_pkg.sv
// rtl/fsm_tx_pkg.sv - shared state encoding, line levels and width helper for the serial transmitter
// Contents:
//   tx_state_e  : frame sequencer states (PARITY exists even when the parity feature is off)
//   *_LEVEL     : line levels driven on `a` outside the payload bits
//   cnt_width() : counter width for a 0..n-1 count, never below 1 bit
package fsm_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic IDLE_LEVEL  = 1'b0;
  localparam logic START_LEVEL = 1'b1;
  localparam logic STOP_LEVEL  = 1'b0;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fsm_bit_timer.sv
// rtl/fsm_bit_timer.sv - per-bit period timer for the serial transmitter
// Ports:
//   clk    in  : system clock, rising edge
//   reset  in  : asynchronous active-low reset
//   clear  in  : synchronous clear of the period count
//   en     in  : advance the count this cycle
//   tick   out : high on the last cycle of each bit period
module fsm_bit_timer
  import fsm_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  // With CLKS_PER_BIT=1 the count is pinned at 0 and tick is high every enabled cycle.
  assign tick = en && (r_cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= tick ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fsm_serial_tx.sv
// rtl/fsm_serial_tx.sv - LSB-first start/stop frame transmitter driving the level line `a`
// Build option: define FSM_TX_PARITY_EN to insert an even-parity bit between data and stop.
// Ports:
//   clk       in  : system clock, rising edge
//   reset     in  : asynchronous active-low reset, aborts any frame in flight
//   din       in  : payload word, latched on accept
//   din_valid in  : producer has a word
//   din_ready out : high only while idle
//   a         out : registered serial line, idle low
//   busy      out : high for the whole frame
//   done      out : one-cycle pulse on the final stop-bit clock
module fsm_serial_tx
  import fsm_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              a,
  output logic              busy,
  output logic              done
);

  localparam int BC_W = cnt_width(DATA_W);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

  tx_state_e         r_state;
  tx_state_e         w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [BC_W-1:0]   r_bit_cnt;
  logic [BC_W-1:0]   w_bit_cnt_nxt;
  logic              r_a;
  logic              w_a_nxt;
  logic              w_tick;
  logic              w_accept;
  logic              w_idle;

  assign w_idle   = (r_state == IDLE);
  assign w_accept = din_valid && w_idle;

  fsm_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .reset(reset),
    .clear(w_idle),
    .en   (!w_idle),
    .tick (w_tick)
  );

`ifdef FSM_TX_PARITY_EN
  logic r_parity;

  // Parity is taken from the word as accepted, before any shifting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= ^din;
    end
  end
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt   = START;
          w_shift_nxt   = din;
          w_bit_cnt_nxt = '0;
        end
      end
      START: begin
        if (w_tick) w_state_nxt = DATA;
      end
      DATA: begin
        if (w_tick) begin
          if (r_bit_cnt == LAST_BIT) begin
`ifdef FSM_TX_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + BC_W'(1);
            w_shift_nxt   = r_shift >> 1;
          end
        end
      end
`ifdef FSM_TX_PARITY_EN
      PARITY: begin
        if (w_tick) w_state_nxt = STOP;
      end
`endif
      STOP: begin
        if (w_tick) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The line is registered from the next-state view so the start bit
  // appears on the cycle right after accept.
  always_comb begin
    w_a_nxt = IDLE_LEVEL;
    case (w_state_nxt)
      START:   w_a_nxt = START_LEVEL;
      DATA:    w_a_nxt = w_shift_nxt[0];
`ifdef FSM_TX_PARITY_EN
      PARITY:  w_a_nxt = r_parity;
`endif
      STOP:    w_a_nxt = STOP_LEVEL;
      default: w_a_nxt = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_a       <= IDLE_LEVEL;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_a       <= w_a_nxt;
    end
  end

  assign a         = r_a;
  assign din_ready = w_idle;
  assign busy      = !w_idle;
  assign done      = (r_state == STOP) && w_tick;

endmodule

// File: tb/tb_fsm_serial_tx.sv
// tb/tb_fsm_serial_tx.sv - directed self-checking bench for fsm_serial_tx
module tb_fsm_serial_tx;

`ifdef FSM_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] din0, din1;
  logic       v0, v1;
  logic       rdy0, rdy1, a0, a1, busy0, busy1, done0, done1;

  int n_vec;
  int n_err;

  fsm_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .reset(reset), .din(din0), .din_valid(v0),
    .din_ready(rdy0), .a(a0), .busy(busy0), .done(done0)
  );

  fsm_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .reset(reset), .din(din1), .din_valid(v1),
    .din_ready(rdy1), .a(a1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line level at cycle c (1 = first start-bit cycle) of a frame.
  function automatic logic exp_a(input logic [7:0] w, input int c, input int cpb);
    int idx;
    idx = (c - 1) / cpb;
    if (idx == 0) return 1'b1;
    if (idx <= 8) return w[idx-1];
    if (PAR == 1 && idx == 9) return ^w;
    return 1'b0;
  endfunction

  task automatic idle_chk(input string tag, input bit sel);
    chk({tag, "_a"},     sel ? a1 : a0, 0);
    chk({tag, "_rdy"},   sel ? rdy1 : rdy0, 1);
    chk({tag, "_busy"},  sel ? busy1 : busy0, 0);
    chk({tag, "_done"},  sel ? done1 : done0, 0);
  endtask

  // Checks cycles 1..last_c of a frame carrying w; at cycle chg_c the
  // producer side is changed to nd/nv. Leaves time at cycle last_c+1.
  task automatic run_frame(input string tag, input bit sel, input logic [7:0] w,
                           input int last_c, input int chg_c,
                           input logic [7:0] nd, input logic nv);
    int cpb;
    int f;
    cpb = sel ? 1 : 4;
    f   = (10 + PAR) * cpb;
    for (int c = 1; c <= last_c; c++) begin
      chk($sformatf("%s_a_c%0d", tag, c),    sel ? a1 : a0, exp_a(w, c, cpb));
      chk($sformatf("%s_done_c%0d", tag, c), sel ? done1 : done0, (c == f));
      chk($sformatf("%s_rdy_c%0d", tag, c),  sel ? rdy1 : rdy0, 0);
      chk($sformatf("%s_busy_c%0d", tag, c), sel ? busy1 : busy0, 1);
      if (c == chg_c) begin
        if (sel) begin din1 = nd; v1 = nv; end
        else     begin din0 = nd; v0 = nv; end
      end
      step();
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    din0 = 8'h00; din1 = 8'h00;
    v0 = 1'b0;    v1 = 1'b0;

    // Reset held 3 cycles, then idle for 20 cycles.
    step(); idle_chk("rst", 0); idle_chk("rst1", 1);
    step(); step();
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      idle_chk($sformatf("idle%0d", i), 0);
    end

    // Single frame 8'hA5, valid dropped right after accept.
    din0 = 8'hA5; v0 = 1'b1;
    step();
    run_frame("a5", 0, 8'hA5, (10 + PAR) * 4, 1, 8'hA5, 1'b0);
    idle_chk("a5_end", 0);
    step();
    idle_chk("a5_end2", 0);

    // Back-to-back with valid held; din changes mid-frame.
    din0 = 8'h3C; v0 = 1'b1;
    step();
    run_frame("3c", 0, 8'h3C, (10 + PAR) * 4, 10, 8'hFF, 1'b1);
    chk("gap_a", a0, 0);
    chk("gap_rdy", rdy0, 1);
    chk("gap_busy", busy0, 0);
    step();
    run_frame("ff", 0, 8'hFF, (10 + PAR) * 4, 1, 8'h00, 1'b0);
    idle_chk("ff_end", 0);
    step(); step();
    idle_chk("ff_end2", 0);

    // Abort during data bit 3 (cycles 17..20) of 8'h0F.
    din0 = 8'h0F; v0 = 1'b1;
    step();
    run_frame("abort", 0, 8'h0F, 17, 1, 8'h0F, 1'b0);
    chk("pre_abort_a", a0, 1);
    reset = 1'b0;
    #1;
    idle_chk("abort_async", 0);
    step(); idle_chk("abort_hold", 0);
    reset = 1'b1;
    step(); idle_chk("abort_rel", 0);
    step(); idle_chk("abort_rel2", 0);
    din0 = 8'h0F; v0 = 1'b1;
    step();
    run_frame("0f", 0, 8'h0F, (10 + PAR) * 4, 1, 8'h0F, 1'b0);
    idle_chk("0f_end", 0);

    // Parity-sensitive word (odd weight).
    din0 = 8'h07; v0 = 1'b1;
    step();
    run_frame("07", 0, 8'h07, (10 + PAR) * 4, 1, 8'h07, 1'b0);
    idle_chk("07_end", 0);

    // One clock per bit.
    idle_chk("cpb1_pre", 1);
    din1 = 8'h01; v1 = 1'b1;
    step();
    run_frame("cpb1", 1, 8'h01, 10 + PAR, 1, 8'h01, 1'b0);
    idle_chk("cpb1_end", 1);
    step();
    idle_chk("cpb1_end2", 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fsm_serial_tx.md
Name: fsm_serial_tx

Overview:
Serial frame transmitter that drives the single-bit level line `a` consumed by the team's level-tracking receiver FSM.
- Accepts a parallel word through a valid/ready handshake.
- Serialises the word LSB-first inside a start/stop frame, holding each bit for a programmable number of clocks.
- Idle line level is 0, which matches the receiver's reset state.

Parameters:
DATA_W, 8, payload width in bits (>=1)
CLKS_PER_BIT, 4, clock cycles each line bit is held (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
din  input  DATA_W  payload word, sampled only on accept
din_valid  input  1  producer has a word
din_ready  output  1  transmitter can accept (high only in IDLE)
a  output  1  serial line, registered
busy  output  1  high from the cycle after accept until frame end
done  output  1  single-cycle pulse on the final clock of the stop bit

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE, a=0, busy=0, done=0, din_ready=1.
  - Shift register and counters cleared.
  - Asserting reset mid-frame aborts the frame immediately; no partial completion and no done pulse.
- Accept:
  - Occurs at a rising edge with din_valid && din_ready.
  - din is latched into the shift register; later changes on din are ignored.
- State machine:
  - IDLE: a=0, din_ready=1. On accept, go to START.
  - START: a=1 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: a=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit. bit_cnt counts 0..DATA_W-1. After bit DATA_W-1, go to STOP.
  - STOP: a=0 for CLKS_PER_BIT cycles. done=1 on the last of these cycles, then go to IDLE.
- Timing:
  - First start-bit cycle on `a` is the cycle after accept (1-cycle latency).
  - Frame length is (DATA_W+2)*CLKS_PER_BIT cycles.
  - din_ready=0 and busy=1 for the whole frame.
  - Back-to-back frames: at most 1 IDLE cycle between a stop bit and the next start bit (accept happens in that IDLE cycle).
- Bit timer: counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. With CLKS_PER_BIT=1, every bit lasts exactly one cycle.
- Widths:
  - bit_cnt is $clog2(DATA_W), minimum 1 bit.
  - Timer is $clog2(CLKS_PER_BIT), minimum 1 bit.
  - No overflow is possible, because counters compare against N-1.
- din_valid held high through a frame does not cause a second accept until IDLE.
- din_valid dropping during a frame has no effect.

Optional Feature:
FSM_TX_PARITY_EN
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - `a` carries an even-parity bit (XOR of the latched data) for CLKS_PER_BIT cycles.
  - Frame length becomes (DATA_W+3)*CLKS_PER_BIT.
- Undefined: no PARITY state, no parity logic, frame as above.

Decomposition:
- Package fsm_tx_pkg:
  - Enum tx_state_e {IDLE, START, DATA, PARITY, STOP}. PARITY is always present in the enum.
  - Constants IDLE_LEVEL=1'b0, START_LEVEL=1'b1, STOP_LEVEL=1'b0.
- One sub-module, fsm_bit_timer:
  - Parameterised by CLKS_PER_BIT.
  - Inputs: clk, reset, clear, en.
  - Output: tick, high on the last cycle of a bit period.

Test Plan:
1. Reset low 3 cycles then high, no din_valid -> a=0, din_ready=1, busy=0, done=0 held for 20 cycles.
2. DATA_W=8, CLKS_PER_BIT=4, send 8'hA5 -> from the cycle after accept, `a` shows:
   - 1 for 4 cycles (start);
   - then bits 1,0,1,0,0,1,0,1, 4 cycles each;
   - then 0 for 4 cycles (stop).
   - done pulses once at cycle 40; din_ready=0 for cycles 1..40.
3. din_valid held high with 8'h3C then 8'hFF -> the two frames are separated by exactly one IDLE cycle, and the second frame carries 8'hFF. din changing mid-frame does not alter the first frame.
4. Reset pulsed low during DATA bit 3 of 8'h0F -> a=0 asynchronously, no done pulse, din_ready=1 after release, next frame transmits correctly.
5. CLKS_PER_BIT=1, send 8'h01 -> 10-cycle frame 1,1,0,0,0,0,0,0,0,0; done on cycle 10.
6. With FSM_TX_PARITY_EN, CLKS_PER_BIT=4:
   - 8'hA5 -> parity bit 0, frame length 44 cycles.
   - 8'h07 -> parity bit 1 in cycles 37..40, stop in cycles 41..44.
